// File: rtl/lr_pkg.sv
// ----------------------------------------------------------------------------
// lr_pkg: shared definitions for the lr_intctl interrupt controller.
//   - lr_state_e  : controller FSM states (IDLE / REQ / HOLD)
//   - LR_IF_ADDR / LR_IE_ADDR : default flag / enable register addresses
//   - LR_VBASE / LR_VSTRIDE   : default vector base and per-channel spacing
//   - lr_vector() : vector computation, wraps modulo 2^16
// ----------------------------------------------------------------------------
package lr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } lr_state_e;

    localparam logic [15:0] LR_IF_ADDR = 16'hFF0F;
    localparam logic [15:0] LR_IE_ADDR = 16'hFFFF;
    localparam logic [15:0] LR_VBASE   = 16'h0040;
    localparam logic [15:0] LR_VSTRIDE = 16'h0008;

    // Channel index width; the controller supports at most 8 channels.
    localparam int LR_SELW = 3;

    // base + stride*idx, all in 16-bit arithmetic so the result wraps.
    function automatic logic [15:0] lr_vector(input logic [15:0] base,
                                              input logic [15:0] stride,
                                              input logic [2:0]  idx);
        logic [15:0] prod;
        prod = stride * {13'd0, idx};
        return base + prod;
    endfunction

endpackage

// File: rtl/lr_prio_enc.sv
// ----------------------------------------------------------------------------
// lr_prio_enc: lowest-index-first priority encoder.
//   req   in  W   request vector
//   idx   out IW  index of the lowest set request bit (0 when none)
//   valid out 1   any request bit set
// ----------------------------------------------------------------------------
module lr_prio_enc #(
    parameter int W  = 5,
    parameter int IW = 3
) (
    input  logic [W-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top down so the lowest set bit is written last and wins.
    always_comb begin
        idx   = {IW{1'b0}};
        valid = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end else begin
                idx   = idx;
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/lr_intctl.sv
// ----------------------------------------------------------------------------
// lr_intctl: small vectored interrupt controller.
//   clock4      in   1      sole clock, rising edge
//   reset       in   1      synchronous active-high reset
//   address     in   16     CPU bus address
//   wdata       in   8      CPU write data
//   load/store  in   1      CPU read / write strobes
//   rdata       out  8      register read data (combinational from address)
//   rsel        out  1      address hits the IF or IE register
//   irq_src     in   NCHAN  interrupt sources (synchronous to clock4)
//   intreq      out  1      interrupt request to the CPU
//   intaddress  out  16     vector of the presented channel (VBASE otherwise)
//   intack      in   1      single-cycle CPU acknowledge
// ----------------------------------------------------------------------------
module lr_intctl
    import lr_pkg::*;
#(
    parameter int                NCHAN      = 5,
    parameter logic [15:0]       VBASE      = LR_VBASE,
    parameter logic [15:0]       VSTRIDE    = LR_VSTRIDE,
    parameter logic [NCHAN-1:0]  LEVEL_MASK = {NCHAN{1'b0}},
    parameter logic [15:0]       IF_ADDR    = LR_IF_ADDR,
    parameter logic [15:0]       IE_ADDR    = LR_IE_ADDR
) (
    input  logic             clock4,
    input  logic             reset,
    input  logic [15:0]      address,
    input  logic [7:0]       wdata,
    input  logic             load,
    input  logic             store,
    output logic [7:0]       rdata,
    output logic             rsel,
    input  logic [NCHAN-1:0] irq_src,
    output logic             intreq,
    output logic [15:0]      intaddress,
    input  logic             intack
);

    lr_state_e              state_r, next_state_s;
    logic [LR_SELW-1:0]     sel_r, sel_next_s, enc_idx_s;
    logic                   enc_valid_s;
    logic [NCHAN-1:0]       if_r, ie_r, src_q_r;
    logic [NCHAN-1:0]       set_s, clr_s, if_base_s, if_next_s, ie_next_s, pending_s;
    logic                   if_hit_s, ie_hit_s, ack_s;
    logic                   intreq_r;
    logic [15:0]            intaddress_r;
    logic [7:0]             rdata_s;
    logic                   load_unused_s;

    // Reads have no side effects, so the read strobe is not needed.
    assign load_unused_s = load;

    assign if_hit_s  = (address == IF_ADDR);
    assign ie_hit_s  = (address == IE_ADDR);
    assign rsel      = if_hit_s | ie_hit_s;

    // Level channels set while high; edge channels only on a 0->1 transition.
    assign set_s     = (irq_src & LEVEL_MASK) | (irq_src & ~src_q_r & ~LEVEL_MASK);
    assign pending_s = if_r & ie_r;

    lr_prio_enc #(
        .W  (NCHAN),
        .IW (LR_SELW)
    ) u_prio (
        .req   (pending_s),
        .idx   (enc_idx_s),
        .valid (enc_valid_s)
    );

    // FSM next-state: sel is only re-latched on the IDLE pass, so a newer
    // higher-priority arrival never disturbs a request already presented.
    always_comb begin
        next_state_s = state_r;
        sel_next_s   = sel_r;
        ack_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enc_valid_s) begin
                    next_state_s = ST_REQ;
                    sel_next_s   = enc_idx_s;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (intack) begin
                    ack_s        = 1'b1;
                    next_state_s = ST_HOLD;
                end else if (!pending_s[sel_r]) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_HOLD: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // One-hot clear mask for the acknowledged channel.
    always_comb begin
        clr_s = {NCHAN{1'b0}};
        for (int i = 0; i < NCHAN; i++) begin
            clr_s[i] = ack_s && (sel_r == LR_SELW'(i));
        end
    end

    // Source sets are OR-ed in last so they beat both a CPU write of 0 and
    // an acknowledge clear on the same cycle.
    assign if_base_s = (store && if_hit_s) ? wdata[NCHAN-1:0] : if_r;
    assign if_next_s = (if_base_s & ~clr_s) | set_s;
    assign ie_next_s = (store && ie_hit_s) ? wdata[NCHAN-1:0] : ie_r;

    // Register readback: unused IF bits read as 1, unused IE bits as 0.
    always_comb begin
        rdata_s = 8'h00;
        if (if_hit_s) begin
            rdata_s            = 8'hFF;
            rdata_s[NCHAN-1:0] = if_r;
        end else if (ie_hit_s) begin
            rdata_s            = 8'h00;
            rdata_s[NCHAN-1:0] = ie_r;
        end else begin
            rdata_s = 8'h00;
        end
    end

    assign rdata = rdata_s;

    // State, flag/enable registers and registered request outputs. src_q
    // tracks irq_src even in reset so releasing reset never makes an edge.
    always_ff @(posedge clock4) begin
        src_q_r <= irq_src;
        if (reset) begin
            state_r      <= ST_IDLE;
            sel_r        <= {LR_SELW{1'b0}};
            if_r         <= {NCHAN{1'b0}};
            ie_r         <= {NCHAN{1'b0}};
            intreq_r     <= 1'b0;
            intaddress_r <= VBASE;
        end else begin
            state_r      <= next_state_s;
            sel_r        <= sel_next_s;
            if_r         <= if_next_s;
            ie_r         <= ie_next_s;
            intreq_r     <= (next_state_s == ST_REQ);
            intaddress_r <= (next_state_s == ST_REQ) ?
                            lr_vector(VBASE, VSTRIDE, sel_next_s) : VBASE;
        end
    end

    assign intreq     = intreq_r;
    assign intaddress = intaddress_r;

endmodule

// File: tb/tb_lr_intctl.sv
// ----------------------------------------------------------------------------
// tb_lr_intctl: directed self-checking bench for lr_intctl. A default
// instance covers edge channels, priority, withdraw, conflict and reset;
// a second 8-channel instance covers a level-sensitive channel.
// ----------------------------------------------------------------------------
module tb_lr_intctl;

    logic        clock4 = 1'b0;
    logic        reset  = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [7:0]  wdata   = 8'h00;
    logic        load    = 1'b0;
    logic        store   = 1'b0;
    logic [7:0]  rdata;
    logic        rsel;
    logic [4:0]  irq_src = 5'h00;
    logic        intreq;
    logic [15:0] intaddress;
    logic        intack  = 1'b0;

    logic [15:0] address8 = 16'h0000;
    logic [7:0]  wdata8   = 8'h00;
    logic        load8    = 1'b0;
    logic        store8   = 1'b0;
    logic [7:0]  rdata8;
    logic        rsel8;
    logic [7:0]  irq8     = 8'h00;
    logic        intreq8;
    logic [15:0] intaddress8;
    logic        intack8  = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [15:0] A_IF = 16'hFF0F;
    localparam logic [15:0] A_IE = 16'hFFFF;

    always #5 clock4 = ~clock4;

    lr_intctl dut (
        .clock4(clock4), .reset(reset), .address(address), .wdata(wdata),
        .load(load), .store(store), .rdata(rdata), .rsel(rsel),
        .irq_src(irq_src), .intreq(intreq), .intaddress(intaddress), .intack(intack)
    );

    lr_intctl #(.NCHAN(8), .LEVEL_MASK(8'h80), .VBASE(16'h0100)) dut8 (
        .clock4(clock4), .reset(reset), .address(address8), .wdata(wdata8),
        .load(load8), .store(store8), .rdata(rdata8), .rsel(rsel8),
        .irq_src(irq8), .intreq(intreq8), .intaddress(intaddress8), .intack(intack8)
    );

    task automatic step();
        @(posedge clock4);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        address = a; wdata = d; store = 1'b1;
        step();
        store = 1'b0;
    endtask

    task automatic cpu_wr8(input logic [15:0] a, input logic [7:0] d);
        address8 = a; wdata8 = d; store8 = 1'b1;
        step();
        store8 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        n_cmp++; if (intreq !== 1'b0) begin n_bad++; $display("FAIL rst_intreq got %0h want 0", intreq); end
        n_cmp++; if (intaddress !== 16'h0040) begin n_bad++; $display("FAIL rst_vec got %h want 0040", intaddress); end
        address = A_IF; #1;
        n_cmp++; if (rdata !== 8'hE0) begin n_bad++; $display("FAIL rst_if got %h want e0", rdata); end
        n_cmp++; if (rsel !== 1'b1) begin n_bad++; $display("FAIL rst_rsel_if got %0h want 1", rsel); end
        address = A_IE; #1;
        n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL rst_ie got %h want 00", rdata); end
        address = 16'h1234; #1;
        n_cmp++; if (rsel !== 1'b0) begin n_bad++; $display("FAIL rsel_miss got %0h want 0", rsel); end
        n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL rdata_miss got %h want 00", rdata); end
        n_cmp++; if (intreq8 !== 1'b0) begin n_bad++; $display("FAIL rst_intreq8 got %0h want 0", intreq8); end
    endtask

    task automatic test_basic();
        cpu_wr(A_IE, 8'h01);
        address = A_IF; irq_src = 5'h01;
        step();
        irq_src = 5'h00;
        n_cmp++; if (rdata !== 8'hE1) begin n_bad++; $display("FAIL basic_if got %h want e1", rdata); end
        n_cmp++; if (intreq !== 1'b0) begin n_bad++; $display("FAIL basic_early got %0h want 0", intreq); end
        step();
        n_cmp++; if (intreq !== 1'b1) begin n_bad++; $display("FAIL basic_req got %0h want 1", intreq); end
        n_cmp++; if (intaddress !== 16'h0040) begin n_bad++; $display("FAIL basic_vec got %h want 0040", intaddress); end
        step();
        n_cmp++; if (intreq !== 1'b1) begin n_bad++; $display("FAIL basic_stay got %0h want 1", intreq); end
        intack = 1'b1;
        step();
        intack = 1'b0;
        n_cmp++; if (intreq !== 1'b0) begin n_bad++; $display("FAIL basic_hold got %0h want 0", intreq); end
        n_cmp++; if (rdata !== 8'hE0) begin n_bad++; $display("FAIL basic_clr got %h want e0", rdata); end
        step();
        n_cmp++; if (intreq !== 1'b0) begin n_bad++; $display("FAIL basic_idle got %0h want 0", intreq); end
    endtask

    task automatic test_priority();
        cpu_wr(A_IE, 8'h1F);
        address = A_IF; irq_src = 5'h14;
        step();
        irq_src = 5'h00;
        n_cmp++; if (rdata !== 8'hF4) begin n_bad++; $display("FAIL prio_if got %h want f4", rdata); end
        step();
        n_cmp++; if (intaddress !== 16'h0050) begin n_bad++; $display("FAIL prio_vec2 got %h want 0050", intaddress); end
        intack = 1'b1;
        step();
        intack = 1'b0;
        n_cmp++; if (rdata !== 8'hF0) begin n_bad++; $display("FAIL prio_clr2 got %h want f0", rdata); end
        n_cmp++; if (intaddress !== 16'h0040) begin n_bad++; $display("FAIL prio_hold_vec got %h want 0040", intaddress); end
        step();
        step();
        n_cmp++; if (intreq !== 1'b1) begin n_bad++; $display("FAIL prio_req4 got %0h want 1", intreq); end
        n_cmp++; if (intaddress !== 16'h0060) begin n_bad++; $display("FAIL prio_vec4 got %h want 0060", intaddress); end
        intack = 1'b1;
        step();
        intack = 1'b0;
        step();
        n_cmp++; if (rdata !== 8'hE0) begin n_bad++; $display("FAIL prio_empty got %h want e0", rdata); end
    endtask

    task automatic test_withdraw();
        irq_src = 5'h08;
        step();
        irq_src = 5'h00;
        step();
        n_cmp++; if (intaddress !== 16'h0058) begin n_bad++; $display("FAIL wd_vec got %h want 0058", intaddress); end
        cpu_wr(A_IE, 8'h00);
        n_cmp++; if (intreq !== 1'b1) begin n_bad++; $display("FAIL wd_still got %0h want 1", intreq); end
        step();
        n_cmp++; if (intreq !== 1'b0) begin n_bad++; $display("FAIL wd_drop got %0h want 0", intreq); end
        n_cmp++; if (intaddress !== 16'h0040) begin n_bad++; $display("FAIL wd_vec_idle got %h want 0040", intaddress); end
        address = A_IF; #1;
        n_cmp++; if (rdata !== 8'hE8) begin n_bad++; $display("FAIL wd_if got %h want e8", rdata); end
        cpu_wr(A_IF, 8'h00);
        address = A_IF; #1;
        n_cmp++; if (rdata !== 8'hE0) begin n_bad++; $display("FAIL wd_ifclr got %h want e0", rdata); end
    endtask

    task automatic test_conflict();
        cpu_wr(A_IE, 8'h02);
        address = A_IF; irq_src = 5'h02;
        step();
        irq_src = 5'h00;
        step();
        n_cmp++; if (intaddress !== 16'h0048) begin n_bad++; $display("FAIL cf_vec got %h want 0048", intaddress); end
        irq_src = 5'h02; intack = 1'b1;
        step();
        irq_src = 5'h00; intack = 1'b0;
        n_cmp++; if (intreq !== 1'b0) begin n_bad++; $display("FAIL cf_hold got %0h want 0", intreq); end
        n_cmp++; if (rdata !== 8'hE2) begin n_bad++; $display("FAIL cf_if got %h want e2", rdata); end
        step();
        n_cmp++; if (intreq !== 1'b0) begin n_bad++; $display("FAIL cf_idle got %0h want 0", intreq); end
        step();
        n_cmp++; if (intreq !== 1'b1) begin n_bad++; $display("FAIL cf_reissue got %0h want 1", intreq); end
        n_cmp++; if (intaddress !== 16'h0048) begin n_bad++; $display("FAIL cf_vec2 got %h want 0048", intaddress); end
        intack = 1'b1;
        step();
        intack = 1'b0;
        step();
        n_cmp++; if (rdata !== 8'hE0) begin n_bad++; $display("FAIL cf_done got %h want e0", rdata); end
    endtask

    task automatic test_reset_in_req();
        cpu_wr(A_IE, 8'h1F);
        address = A_IF; irq_src = 5'h01;
        step();
        step();
        n_cmp++; if (intreq !== 1'b1) begin n_bad++; $display("FAIL rr_req got %0h want 1", intreq); end
        reset = 1'b1; intack = 1'b1;
        step();
        reset = 1'b0; intack = 1'b0;
        n_cmp++; if (intreq !== 1'b0) begin n_bad++; $display("FAIL rr_drop got %0h want 0", intreq); end
        n_cmp++; if (rdata !== 8'hE0) begin n_bad++; $display("FAIL rr_if got %h want e0", rdata); end
        step(); step(); step();
        n_cmp++; if (intreq !== 1'b0) begin n_bad++; $display("FAIL rr_noreq got %0h want 0", intreq); end
        n_cmp++; if (rdata !== 8'hE0) begin n_bad++; $display("FAIL rr_noedge got %h want e0", rdata); end
        irq_src = 5'h00;
        step();
    endtask

    task automatic test_level8();
        cpu_wr8(A_IE, 8'h80);
        address8 = A_IF; irq8 = 8'h80;
        step();
        n_cmp++; if (rdata8 !== 8'h80) begin n_bad++; $display("FAIL lv_if got %h want 80", rdata8); end
        n_cmp++; if (intreq8 !== 1'b0) begin n_bad++; $display("FAIL lv_early got %0h want 0", intreq8); end
        step();
        n_cmp++; if (intreq8 !== 1'b1) begin n_bad++; $display("FAIL lv_req got %0h want 1", intreq8); end
        n_cmp++; if (intaddress8 !== 16'h0138) begin n_bad++; $display("FAIL lv_vec got %h want 0138", intaddress8); end
        intack8 = 1'b1;
        step();
        intack8 = 1'b0;
        n_cmp++; if (intreq8 !== 1'b0) begin n_bad++; $display("FAIL lv_hold got %0h want 0", intreq8); end
        n_cmp++; if (rdata8 !== 8'h80) begin n_bad++; $display("FAIL lv_reset_if got %h want 80", rdata8); end
        step();
        step();
        n_cmp++; if (intreq8 !== 1'b1) begin n_bad++; $display("FAIL lv_return got %0h want 1", intreq8); end
        n_cmp++; if (intaddress8 !== 16'h0138) begin n_bad++; $display("FAIL lv_vec2 got %h want 0138", intaddress8); end
        irq8 = 8'h00; intack8 = 1'b1;
        step();
        intack8 = 1'b0;
        step();
        n_cmp++; if (rdata8 !== 8'h00) begin n_bad++; $display("FAIL lv_clear got %h want 00", rdata8); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_withdraw();
        test_conflict();
        test_reset_in_req();
        test_level8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lr_intctl.md
LR_INTCTL -- requirements
Module: lr_intctl

Interface
REQ-001 Parameter NCHAN, default 5: number of interrupt channels, legal range 1..8.
REQ-002 Parameter VBASE, default 16'h0040: vector of channel 0.
REQ-003 Parameter VSTRIDE, default 16'h0008: vector spacing per channel.
REQ-004 Parameter LEVEL_MASK, default all zero (NCHAN bits): bit i=1 makes channel i level-sensitive, else rising-edge.
REQ-005 Parameters IF_ADDR (default 16'hFF0F) and IE_ADDR (default 16'hFFFF): register addresses.
REQ-006 clock4  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 address  in  16  CPU bus address.
REQ-009 wdata  in  8  CPU write data.
REQ-010 load / store  in  1 each  CPU read / write strobes for the current address.
REQ-011 rdata  out  8  register read data, combinational from address.
REQ-012 rsel  out  1  high when address equals IF_ADDR or IE_ADDR.
REQ-013 irq_src  in  NCHAN  interrupt sources, synchronous to clock4.
REQ-014 intreq  out  1  request to CPU.
REQ-015 intaddress  out  16  vector of the presented channel.
REQ-016 intack  in  1  single-cycle CPU acknowledge.

Function
REQ-017 Edge channel: IF[i] sets on the clock where irq_src[i]=1 and the registered previous sample src_q[i]=0.
REQ-018 Level channel: IF[i] sets on every clock where irq_src[i]=1.
REQ-019 store with address==IF_ADDR writes IF from wdata[NCHAN-1:0]; address==IE_ADDR writes IE likewise; higher bits are ignored.
REQ-020 rdata: at IF_ADDR, unused bits read 1, IF in low bits; at IE_ADDR, unused bits read 0; else 8'h00.
REQ-021 Same-cycle conflicts on an IF bit: a source set beats a CPU write of 0 and beats an intack clear.
REQ-022 pending = IF & IE; the selected channel is the lowest-index pending bit.
REQ-023 FSM states IDLE, REQ, HOLD.
REQ-024 IDLE: if pending!=0, latch selected index into sel, go to REQ; else stay; intreq=0.
REQ-025 REQ: intreq=1; intaddress = VBASE + VSTRIDE*sel, held stable for the whole state.
REQ-026 REQ and intack=1: clear IF[sel] (subject to REQ-021), go to HOLD.
REQ-027 REQ and pending[sel]=0 without intack (CPU cleared IF or IE): withdraw, go to IDLE, intreq drops next cycle.
REQ-028 A higher-priority arrival during REQ does not change sel; it is taken on the next IDLE pass.
REQ-029 HOLD: intreq=0 for exactly one cycle, then IDLE.
REQ-030 intack outside REQ is ignored.
REQ-031 Latency: source high at edge k -> IF visible after k -> intreq high after k+1.
REQ-032 intaddress = VBASE when not in REQ.
REQ-033 16-bit vector arithmetic wraps modulo 2^16.

Reset
REQ-034 While reset=1 at a clock edge: IF=0, IE=0, state=IDLE, sel=0, intreq=0, and src_q loads irq_src, so no edge is generated at release.
REQ-035 Reset asserted in REQ drops intreq on the next edge; a pending ack is discarded.

Structure
REQ-036 Shared package lr_pkg holds the FSM state enum, default IF/IE addresses and default VBASE/VSTRIDE.
REQ-037 Sub-module lr_prio_enc (parametrised width, lowest-index-first, outputs index and valid) performs the selection.

Verification
REQ-038 Defaults; IE=5'h01; pulse irq_src[0] -> IF=1 after 1 clock, intreq after 2, intaddress=16'h0040; intack -> IF[0]=0, intreq low for the HOLD cycle.
REQ-039 IE=5'h1F; irq_src[4] and [2] rise together -> sel=2, intaddress=16'h0050; after ack and HOLD -> intaddress=16'h0060.
REQ-040 In REQ for channel 3, CPU stores IE=0 -> intreq drops next cycle, no ack needed; IF reads 8'hE8.
REQ-041 irq_src[1] edge on the same clock as intack for channel 1 -> IF[1] remains 1 and the request re-issues after HOLD.
REQ-042 NCHAN=8, LEVEL_MASK=8'h80, VBASE=16'h0100: hold irq_src[7] high, IE=8'h80 -> vector 16'h0138; after ack IF[7] re-sets and intreq returns.
REQ-043 Assert reset in REQ with irq_src held high -> intreq=0 and IF=0 after one edge; no request after release.
